// File: rtl/cordic_vec.sv
// cordic_vec: pipelined vectoring-mode CORDIC mapping (x, y) to atan2 angle in degrees and magnitude.
// Define CORDIC_VEC_GAIN_COMP_EN to add one output stage that removes the CORDIC gain from mag_o.
module cordic_vec #(
    parameter int XY_DW           = 32,
    parameter int ANGLE_DW        = 32,
    parameter int ANGLE_PRECISION = 16,
    parameter int PIPEDEEP        = 16,
    parameter int KN              = 39796
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic signed [XY_DW-1:0]    x_i,
    input  logic signed [XY_DW-1:0]    y_i,
    output logic                       en_o,
    output logic [ANGLE_DW-1:0]        angle_o,
    output logic [XY_DW+1:0]           mag_o
);

    localparam int W = XY_DW + 2;

    localparam logic signed [ANGLE_DW-1:0] DEG90  = ANGLE_DW'(longint'(90)  << ANGLE_PRECISION);
    localparam logic signed [ANGLE_DW-1:0] DEG270 = ANGLE_DW'(longint'(270) << ANGLE_PRECISION);
    localparam logic signed [ANGLE_DW-1:0] DEG360 = ANGLE_DW'(longint'(360) << ANGLE_PRECISION);

    // atan(2^-k) in degrees scaled by 2^16; table is shared with the rotation-mode generator.
    function automatic logic signed [ANGLE_DW-1:0] atan_lut(input int k);
        int v;
        case (k)
            0:       v = 2949120;
            1:       v = 1740992;
            2:       v = 919872;
            3:       v = 466944;
            4:       v = 234368;
            5:       v = 117312;
            6:       v = 58688;
            7:       v = 29312;
            8:       v = 14656;
            9:       v = 7360;
            10:      v = 3648;
            11:      v = 1856;
            12:      v = 896;
            13:      v = 448;
            14:      v = 256;
            15:      v = 128;
            default: v = 0;
        endcase
        return ANGLE_DW'(v);
    endfunction

    // Base quadrant angle plus residual, folded back into [0, 360); the positive x axis is forced to 0.
    function automatic logic signed [ANGLE_DW-1:0] wrap_angle(
        input logic signed [ANGLE_DW-1:0] base,
        input logic signed [ANGLE_DW-1:0] z,
        input logic                       zax
    );
        logic signed [ANGLE_DW-1:0] a;
        a = base + z;
        if (a[ANGLE_DW-1]) a = a + DEG360;
        if (a >= DEG360)   a = a - DEG360;
        if (zax)           a = '0;
        return a;
    endfunction

`ifdef CORDIC_VEC_GAIN_COMP_EN
    function automatic logic signed [W-1:0] gain_comp(input logic signed [W-1:0] x);
        return W'(($signed((W+18)'(x)) * $signed((W+18)'(KN))) >>> 16);
    endfunction
`endif

    logic signed [W-1:0]        x_ext;
    logic signed [W-1:0]        y_ext;
    logic signed [W-1:0]        x_fold;
    logic signed [W-1:0]        y_fold;
    logic signed [ANGLE_DW-1:0] base_fold;
    logic                       zax_fold;

    logic                       vld_p  [0:PIPEDEEP];
    logic signed [W-1:0]        x_p    [0:PIPEDEEP];
    logic signed [W-1:0]        y_p    [0:PIPEDEEP];
    logic signed [ANGLE_DW-1:0] z_p    [0:PIPEDEEP];
    logic signed [ANGLE_DW-1:0] base_p [0:PIPEDEEP];
    logic                       zax_p  [0:PIPEDEEP];

    logic                       vld_pout;
    logic signed [ANGLE_DW-1:0] ang_pout;
    logic signed [W-1:0]        mag_pout;

    // Widening by two bits keeps -(-2^(XY_DW-1)) and the ~1.65x gain growth representable.
    always_comb begin
        x_ext     = {{2{x_i[XY_DW-1]}}, x_i};
        y_ext     = {{2{y_i[XY_DW-1]}}, y_i};
        x_fold    = x_ext;
        y_fold    = y_ext;
        base_fold = '0;
        zax_fold  = (y_i == '0) && !x_i[XY_DW-1];
        if (x_i[XY_DW-1]) begin
            if (!y_i[XY_DW-1]) begin
                x_fold    = y_ext;
                y_fold    = -x_ext;
                base_fold = DEG90;
            end else begin
                x_fold    = -y_ext;
                y_fold    = x_ext;
                base_fold = DEG270;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= PIPEDEEP; k++) begin
                vld_p[k]  <= 1'b0;
                x_p[k]    <= '0;
                y_p[k]    <= '0;
                z_p[k]    <= '0;
                base_p[k] <= '0;
                zax_p[k]  <= 1'b0;
            end
            vld_pout <= 1'b0;
            ang_pout <= '0;
            mag_pout <= '0;
        end else begin
            // stage 0: half-plane fold
            vld_p[0] <= en_i;
            if (en_i) begin
                x_p[0]    <= x_fold;
                y_p[0]    <= y_fold;
                z_p[0]    <= '0;
                base_p[0] <= base_fold;
                zax_p[0]  <= zax_fold;
            end
            // stages 1..PIPEDEEP: micro-rotations driving y toward zero
            for (int k = 0; k < PIPEDEEP; k++) begin
                vld_p[k+1] <= vld_p[k];
                if (vld_p[k]) begin
                    if (!y_p[k][W-1]) begin
                        x_p[k+1] <= x_p[k] + (y_p[k] >>> k);
                        y_p[k+1] <= y_p[k] - (x_p[k] >>> k);
                        z_p[k+1] <= z_p[k] + atan_lut(k);
                    end else begin
                        x_p[k+1] <= x_p[k] - (y_p[k] >>> k);
                        y_p[k+1] <= y_p[k] + (x_p[k] >>> k);
                        z_p[k+1] <= z_p[k] - atan_lut(k);
                    end
                    base_p[k+1] <= base_p[k];
                    zax_p[k+1]  <= zax_p[k];
                end
            end
            // output stage: angle reconstruction and wrap
            vld_pout <= vld_p[PIPEDEEP];
            if (vld_p[PIPEDEEP]) begin
                ang_pout <= wrap_angle(base_p[PIPEDEEP], z_p[PIPEDEEP], zax_p[PIPEDEEP]);
                mag_pout <= x_p[PIPEDEEP];
            end
        end
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic                       vld_pgc;
    logic signed [ANGLE_DW-1:0] ang_pgc;
    logic signed [W-1:0]        mag_pgc;

    // gain stage: magnitude scaled by KN/2^16, angle carried along to stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pgc <= 1'b0;
            ang_pgc <= '0;
            mag_pgc <= '0;
        end else begin
            vld_pgc <= vld_pout;
            if (vld_pout) begin
                ang_pgc <= ang_pout;
                mag_pgc <= gain_comp(mag_pout);
            end
        end
    end

    assign en_o    = vld_pgc;
    assign angle_o = ang_pgc;
    assign mag_o   = mag_pgc;
`else
    assign en_o    = vld_pout;
    assign angle_o = ang_pout;
    assign mag_o   = mag_pout;
`endif

endmodule

// File: tb/tb_cordic_vec.sv
// tb_cordic_vec: scoreboard bench for cordic_vec with directed vectors, bursts, gaps and a mid-stream reset.
`timescale 1ns/1ps
module tb_cordic_vec;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT      = 19;
    localparam real MAG_GAIN = 1.6467602581 * 39796.0 / 65536.0;
`else
    localparam int  LAT      = 18;
    localparam real MAG_GAIN = 1.6467602581;
`endif
    localparam real         DEG     = 65536.0;
    localparam real         ANG_TOL = 1311.0;
    localparam real         PI      = 3.14159265358979;
    localparam logic [31:0] FULL    = 32'd23592960;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en_i = 1'b0;
    logic signed [31:0] x_i = '0;
    logic signed [31:0] y_i = '0;
    logic               en_o;
    logic [31:0]        angle_o;
    logic [33:0]        mag_o;

    cordic_vec dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_i),
        .x_i     (x_i),
        .y_i     (y_i),
        .en_o    (en_o),
        .angle_o (angle_o),
        .mag_o   (mag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        real         ang;
        real         mag;
        bit          ang_exact;
        bit          mag_exact;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    real         mon_d;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    // Drive one sample for the next edge and queue its expected result.
    task automatic send(input int x, input int y, input real ang_deg, input bit ang_exact);
        exp_t e;
        en_i = 1'b1;
        x_i  = x;
        y_i  = y;
        e.due       = cyc + LAT;
        e.ang       = ang_deg;
        e.mag       = MAG_GAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.ang_exact = ang_exact;
        e.mag_exact = (x == 0) && (y == 0);
        sbq.push_back(e);
        @(posedge clk); #1;
        en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        en_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_i  = 1'b0;
        @(posedge clk); #1;
        check("midstream_reset_clear", en_o === 1'b0 && angle_o === 32'd0 && mag_o === 34'd0,
              $sformatf("en_o=%b angle=%0d mag=%0d", en_o, angle_o, mag_o), "all zero");
        sbq.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (en_o === 1'b1) begin
            check("en_o_expected", sbq.size() != 0, $sformatf("en_o=1 at cycle %0d", cyc), "a queued sample");
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check("latency", cyc == mon_e.due, $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", mon_e.due));
                check("angle_range", angle_o < FULL, $sformatf("%0d", angle_o), "< 23592960");
                if (mon_e.ang_exact) begin
                    check("angle_exact", angle_o == 32'd0, $sformatf("%0d", angle_o), "0");
                end else begin
                    mon_d = real'(angle_o) - mon_e.ang * DEG;
                    if (mon_d > 180.0 * DEG)  mon_d = mon_d - 360.0 * DEG;
                    if (mon_d < -180.0 * DEG) mon_d = mon_d + 360.0 * DEG;
                    check("angle", mon_d <= ANG_TOL && mon_d >= -ANG_TOL,
                          $sformatf("%0d", angle_o), $sformatf("%0.1f +/-1311", mon_e.ang * DEG));
                end
                if (mon_e.mag_exact) begin
                    check("mag_exact", mag_o == 34'd0, $sformatf("%0d", mag_o), "0");
                end else begin
                    mon_d = real'(mag_o) - mon_e.mag;
                    check("mag", mon_d <= 16.0 + mon_e.mag / 16384.0 && mon_d >= -(16.0 + mon_e.mag / 16384.0),
                          $sformatf("%0d", mag_o), $sformatf("%0.1f", mon_e.mag));
                end
            end
        end
    end

    // Directed vectors: x, y and hand-derived atan2 in degrees.
    int  dx [13] = '{65536, -65536, -65536, 65536, -65536, 0, 65536, 0, 0,
                     int'(32'h8000_0000), int'(32'h7fff_ffff), 196608, -1000000};
    int  dy [13] = '{65536, 65536, -65536, -65536, 0, 0, 0, 65536, -65536,
                     int'(32'h8000_0000), 0, 262144, 1};
    real da [13] = '{45.0, 135.0, 225.0, 315.0, 180.0, 0.0, 0.0, 90.0, 270.0,
                     225.0, 0.0, 53.1301024, 179.9999427};
    bit  dz [13] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        int  rx;
        int  ry;
        real ra;

        // reset held with en_i high: nothing may come out
        rst_n = 1'b0;
        en_i  = 1'b1;
        x_i   = 12345;
        y_i   = -999;
        repeat (5) begin
            @(negedge clk);
            check("reset_outputs", en_o === 1'b0 && angle_o === 32'd0 && mag_o === 34'd0,
                  $sformatf("en_o=%b angle=%0d mag=%0d", en_o, angle_o, mag_o), "all zero");
        end
        rst_n = 1'b1;
        en_i  = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            send(dx[i], dy[i], da[i], dz[i]);
            if (i >= 4) idle(i % 3);
        end
        idle(LAT + 4);

        for (int i = 0; i < 200; i++) begin
            if (i == 100) do_reset();
            rx = int'($urandom);
            ry = int'($urandom);
            if (rx > -65536 && rx < 65536 && ry > -65536 && ry < 65536) rx = 1 << 20;
            ra = $atan2(real'(ry), real'(rx)) * 180.0 / PI;
            if (ra < 0.0) ra = ra + 360.0;
            send(rx, ry, ra, 1'b0);
            if (i % 10 >= 3) idle($urandom_range(0, 3));
        end

        for (int t = 0; t < 4 * LAT && sbq.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", sbq.size() == 0, $sformatf("%0d outstanding", sbq.size()), "0 outstanding");
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
